// File: rtl/fma_mem_pkg.sv
// rtl/fma_mem_pkg.sv - opcodes, instruction field positions, error bits and FSM states
package fma_mem_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_SMA    = 4'b0110,
    OP_LOADI  = 4'b0111,
    OP_LOADB  = 4'b1010,
    OP_WRITEB = 4'b1100,
    OP_SENDL  = 4'b1110
  } opcode_e;

  // Instruction bit 0 is the opcode MSB (ascending [0:N-1] vector)
  localparam int OPC_FIRST = 0;
  localparam int OPC_LAST  = 3;
  localparam int REG_FIRST = 4;
  localparam int REG_LAST  = 7;
  localparam int IMM_FIRST = 8;
  localparam int IMM_LAST  = 23;

  localparam int ERR_OPCODE    = 0;
  localparam int ERR_LOADI_IDX = 1;
  localparam int ERR_SMA_ADDR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADB_WAIT,
    ST_READ
  } state_e;

endpackage

// File: rtl/fma_line_bram.sv
// rtl/fma_line_bram.sv - single-port read-first line BRAM, registered address and output (2-cycle read)
module fma_line_bram #(
  parameter  int LINE_WIDTH = 96,
  parameter  int DEPTH      = 384,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o
);

  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_q;
  logic [LINE_WIDTH-1:0] dout_q;
  logic                  dvalid_q;

  // Array contents survive reset
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_q   <= '0;
      rd_q     <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      rd_q     <= en_i && !we_i;
      dvalid_q <= rd_q;
      if (en_i && !we_i) addr_q <= addr_i;
      if (rd_q) dout_q <= mem[addr_q];
    end
  end

  assign rdata_o  = dout_q;
  assign rvalid_o = dvalid_q;

endmodule

// File: rtl/fma_line_memory.sv
// rtl/fma_line_memory.sv - instruction-driven operand line cache for the FMA array
// Optional burst WRITEB reads enabled by defining FMA_LINE_MEM_BURST_EN.
module fma_line_memory
  import fma_mem_pkg::*;
#(
  parameter  int FMA_COUNT         = 2,
  parameter  int WORD_WIDTH        = 16,
  parameter  int DEPTH             = 384,
  parameter  int INSTRUCTION_WIDTH = 32,
  localparam int WORDS_PER_LINE    = 3 * FMA_COUNT,
  localparam int ADDR_WIDTH        = $clog2(DEPTH),
  localparam int LINE_WIDTH        = WORDS_PER_LINE * WORD_WIDTH
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [0:INSTRUCTION_WIDTH-1] instr_in,
  input  logic                         instr_valid_in,
  output logic                         instr_ready_out,
  input  logic [LINE_WIDTH-1:0]        buf_line_in,
  input  logic                         buf_valid_in,
  output logic                         buf_ready_out,
  output logic [LINE_WIDTH-1:0]        abc_out,
  output logic                         abc_valid_out,
  output logic                         idle_out,
  output logic [2:0]                   err_out
);

  logic [3:0]  op_f;
  logic [3:0]  reg_f;
  logic [15:0] imm_f;
  logic        unused_instr;

  assign op_f         = instr_in[OPC_FIRST:OPC_LAST];
  assign reg_f        = instr_in[REG_FIRST:REG_LAST];
  assign imm_f        = instr_in[IMM_FIRST:IMM_LAST];
  assign unused_instr = ^instr_in[IMM_LAST+1:INSTRUCTION_WIDTH-1];

  state_e                state_q;
  logic                  ready_q, buf_ready_q, idle_q;
  logic [2:0]            err_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] temp_q;
  logic [4:0]            rd_left_q;
  logic                  wr_pend_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LINE_WIDTH-1:0] wr_data_q;
  logic [4:0]            burst_len;

  assign addr_d = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;

`ifdef FMA_LINE_MEM_BURST_EN
  assign burst_len = {1'b0, reg_f} + 5'd1;
`else
  assign burst_len = 5'd1;
`endif

  logic instr_fire, buf_fire, rd_issue;
  assign instr_fire = instr_valid_in && ready_q;
  assign buf_fire   = buf_valid_in && buf_ready_q;
  assign rd_issue   = (state_q == ST_READ) && (rd_left_q != '0);

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      buf_ready_q <= 1'b0;
      idle_q      <= 1'b1;
      err_q       <= '0;
      addr_q      <= '0;
      temp_q      <= '0;
      rd_left_q   <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_pend_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          idle_q  <= 1'b1;
          if (instr_fire) begin
            case (op_f)
              OP_NOP: ;
              OP_SMA: begin
                if (32'(imm_f) >= DEPTH) err_q[ERR_SMA_ADDR] <= 1'b1;
                else addr_q <= ADDR_WIDTH'(imm_f);
              end
              OP_LOADI: begin
                if (32'(reg_f) >= WORDS_PER_LINE) err_q[ERR_LOADI_IDX] <= 1'b1;
                else temp_q[(WORDS_PER_LINE-1-int'(reg_f))*WORD_WIDTH +: WORD_WIDTH] <= WORD_WIDTH'(imm_f);
              end
              OP_SENDL: begin
                wr_pend_q <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= temp_q;
                temp_q    <= '0;
                addr_q    <= addr_d;
              end
              OP_LOADB: begin
                state_q     <= ST_LOADB_WAIT;
                ready_q     <= 1'b0;
                idle_q      <= 1'b0;
                buf_ready_q <= 1'b1;
              end
              OP_WRITEB: begin
                state_q   <= ST_READ;
                ready_q   <= 1'b0;
                idle_q    <= 1'b0;
                rd_left_q <= burst_len;
              end
              default: err_q[ERR_OPCODE] <= 1'b1;
            endcase
          end
        end
        ST_LOADB_WAIT: begin
          if (buf_fire) begin
            wr_pend_q   <= 1'b1;
            wr_addr_q   <= addr_q;
            wr_data_q   <= buf_line_in;
            addr_q      <= addr_d;
            state_q     <= ST_IDLE;
            buf_ready_q <= 1'b0;
            ready_q     <= 1'b1;
            idle_q      <= 1'b1;
          end
        end
        ST_READ: begin
          // Leave READ as the last line enters the output stage so ready rises with the final pulse
          if (rd_left_q != '0) begin
            rd_left_q <= rd_left_q - 5'd1;
            addr_q    <= addr_d;
          end else begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            idle_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Writes land one cycle after their handshake and never overlap read issue
  logic                  bram_we, bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  assign bram_we   = wr_pend_q && rst_n_in;
  assign bram_en   = bram_we || (rd_issue && rst_n_in);
  assign bram_addr = wr_pend_q ? wr_addr_q : addr_q;

  fma_line_bram #(
    .LINE_WIDTH(LINE_WIDTH),
    .DEPTH     (DEPTH)
  ) u_bram (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .en_i    (bram_en),
    .we_i    (bram_we),
    .addr_i  (bram_addr),
    .wdata_i (wr_data_q),
    .rdata_o (abc_out),
    .rvalid_o(abc_valid_out)
  );

  assign instr_ready_out = ready_q;
  assign buf_ready_out   = buf_ready_q;
  assign idle_out        = idle_q;
  assign err_out         = err_q;

endmodule
